sonar_ping_sequencer: RTL and testbench



---
 rtl/sonar_ping_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_sonar_ping_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_ping_sequencer.sv
// Ultrasonic ping sequencer: 40 kHz transmit burst, receiver blanking, dual echo
// time-stamping, and hand-off of both times of flight to the math unit.
module sonar_ping_sequencer #(
    parameter int unsigned HALF_PERIOD    = 625,
    parameter int unsigned BURST_CYCLES   = 8,
    parameter int unsigned BLANK_CYCLES   = 25000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned TOF_W          = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             auto_en,
    input  logic [31:0]      period_cycles,
    input  logic             tripone,
    input  logic             triptwo,
    input  logic             math_done,
    output logic             tx_out,
    output logic             math_start,
    output logic [TOF_W-1:0] tof_one,
    output logic [TOF_W-1:0] tof_two,
    output logic [1:0]       timeout_flags,
    output logic             valid,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int unsigned      BL          = 2 * BURST_CYCLES * HALF_PERIOD;
    localparam int unsigned      HP_W        = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HP_W-1:0]  HP_LAST     = HP_W'(HALF_PERIOD - 1);
    localparam logic [TOF_W-1:0] BURST_LAST  = TOF_W'(BL - 1);
    localparam logic [TOF_W-1:0] BLANK_LAST  = TOF_W'(BL + BLANK_CYCLES - 1);
    localparam logic [TOF_W-1:0] TIMEOUT_VAL = TOF_W'(TIMEOUT_CYCLES);
    localparam logic [TOF_W-1:0] TOF_MAX     = {TOF_W{1'b1}};

    typedef enum logic [2:0] {IDLE, BURST, BLANK, LISTEN, COMPUTE, HOLDOFF} state_t;

    state_t           state;
    state_t           state_next;
    logic [TOF_W-1:0] tof_cnt;
    logic [31:0]      period_cnt;
    logic [HP_W-1:0]  hp_cnt;
    logic             tx_level;
    logic [1:0]       sync_one;
    logic [1:0]       sync_two;
    logic             one_d;
    logic             two_d;
    logic             got_one;
    logic             got_two;
    logic             rise_one;
    logic             rise_two;
    logic             cap_one;
    logic             cap_two;
    logic             enter_burst;
    logic             enter_compute;
    logic             timeout_hit;
    logic             compute_done;
    logic             period_reached;
    logic             counting;

    // Edge detectors run in every state, so a level already high on entering LISTEN is not an edge.
    assign rise_one       = sync_one[1] & ~one_d;
    assign rise_two       = sync_two[1] & ~two_d;
    assign period_reached = ({1'b0, period_cnt} + 33'd1) >= {1'b0, period_cycles};
    assign counting       = (state == BURST) || (state == BLANK) || (state == LISTEN);

    assign tx_out    = (state == BURST) & tx_level;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Math handshake: math_start is a one-cycle request issued on COMPUTE entry; math_done
    // is a level sampled only while in COMPUTE (no backpressure, ignored in all other states).
    always_comb begin
        state_next    = state;
        enter_burst   = 1'b0;
        enter_compute = 1'b0;
        timeout_hit   = 1'b0;
        compute_done  = 1'b0;
        cap_one       = 1'b0;
        cap_two       = 1'b0;
        case (state)
            IDLE: begin
                if (start || auto_en) begin
                    state_next  = BURST;
                    enter_burst = 1'b1;
                end
            end
            BURST: begin
                if (tof_cnt == BURST_LAST) state_next = BLANK;
            end
            BLANK: begin
                if (tof_cnt == BLANK_LAST) state_next = LISTEN;
            end
            LISTEN: begin
                cap_one = rise_one & ~got_one;
                cap_two = rise_two & ~got_two;
                if ((got_one | cap_one) && (got_two | cap_two)) begin
                    state_next    = COMPUTE;
                    enter_compute = 1'b1;
                end else if (tof_cnt >= TIMEOUT_VAL) begin
                    state_next  = HOLDOFF;
                    timeout_hit = 1'b1;
                end
            end
            COMPUTE: begin
                if (math_done) begin
                    state_next   = HOLDOFF;
                    compute_done = 1'b1;
                end
            end
            HOLDOFF: begin
                if (!auto_en) begin
                    state_next = IDLE;
                end else if (period_reached) begin
                    state_next  = BURST;
                    enter_burst = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tof_cnt       <= '0;
            period_cnt    <= '0;
            hp_cnt        <= '0;
            tx_level      <= 1'b0;
            sync_one      <= '0;
            sync_two      <= '0;
            one_d         <= 1'b0;
            two_d         <= 1'b0;
            got_one       <= 1'b0;
            got_two       <= 1'b0;
            tof_one       <= '0;
            tof_two       <= '0;
            timeout_flags <= '0;
            math_start    <= 1'b0;
            valid         <= 1'b0;
        end else begin
            sync_one   <= {sync_one[0], tripone};
            sync_two   <= {sync_two[0], triptwo};
            one_d      <= sync_one[1];
            two_d      <= sync_two[1];
            math_start <= enter_compute;
            valid      <= compute_done | timeout_hit;

            if (enter_burst) begin
                tof_cnt       <= '0;
                period_cnt    <= '0;
                hp_cnt        <= '0;
                tx_level      <= 1'b1;
                got_one       <= 1'b0;
                got_two       <= 1'b0;
                timeout_flags <= '0;
            end else begin
                if (period_cnt != 32'hFFFF_FFFF) period_cnt <= period_cnt + 32'd1;
                if (counting && (tof_cnt != TOF_MAX)) tof_cnt <= tof_cnt + TOF_W'(1);
                if (state == BURST) begin
                    if (hp_cnt == HP_LAST) begin
                        hp_cnt   <= '0;
                        tx_level <= ~tx_level;
                    end else begin
                        hp_cnt <= hp_cnt + HP_W'(1);
                    end
                end
            end

            if (cap_one) begin
                tof_one <= tof_cnt;
                got_one <= 1'b1;
            end
            if (cap_two) begin
                tof_two <= tof_cnt;
                got_two <= 1'b1;
            end
            // A capture in the timeout cycle wins over the miss flag for that receiver.
            if (timeout_hit) begin
                if (!(got_one | cap_one)) begin
                    tof_one          <= '0;
                    timeout_flags[0] <= 1'b1;
                end
                if (!(got_two | cap_two)) begin
                    tof_two          <= '0;
                    timeout_flags[1] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Directed bench for sonar_ping_sequencer: a timeline model predicts tx/busy/math_start/valid
// every cycle and queues each expected result; literal checks pin the hand-computed values.
module tb_sonar_ping_sequencer;

    localparam int HP   = 4;
    localparam int BC   = 2;
    localparam int BLK  = 10;
    localparam int TMO  = 200;
    localparam int TW   = 24;
    localparam int BL   = 2 * BC * HP;
    localparam int LS   = BL + BLK;
    localparam int NONE = -1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          auto_en;
    logic [31:0]   period_cycles;
    logic          tripone;
    logic          triptwo;
    logic          math_done;
    logic          tx_out;
    logic          math_start;
    logic [TW-1:0] tof_one;
    logic [TW-1:0] tof_two;
    logic [1:0]    timeout_flags;
    logic          valid;
    logic          busy;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    sonar_ping_sequencer #(
        .HALF_PERIOD(HP), .BURST_CYCLES(BC), .BLANK_CYCLES(BLK),
        .TIMEOUT_CYCLES(TMO), .TOF_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .auto_en(auto_en),
        .period_cycles(period_cycles), .tripone(tripone), .triptwo(triptwo),
        .math_done(math_done), .tx_out(tx_out), .math_start(math_start),
        .tof_one(tof_one), .tof_two(tof_two), .timeout_flags(timeout_flags),
        .valid(valid), .busy(busy), .dbg_state(dbg_state)
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc_n = 0;
    int   rel = 0;
    int   ms_cnt = 0;
    int   valid_cnt = 0;
    int   valid_cyc = 0;
    int   tx_edges = 0;
    logic tx_prev = 1'b0;
    int   rises[$];
    logic [2*TW+1:0] exp_q[$];

    // Timeline model: m_t is the cycle index since the current BURST entry.
    bit         m_run, m_ended, m_c1, m_c2;
    int         m_t, m_ms, m_vt, m_tof1, m_tof2;
    logic [1:0] m_flags;
    logic [2:0] h1, h2;
    logic       exp_busy, exp_tx, exp_ms, exp_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, want, $time);
        end
    endtask

    task automatic model_new();
        m_ended = 1'b0;
        m_c1    = 1'b0;
        m_c2    = 1'b0;
        m_ms    = NONE;
        m_vt    = NONE;
        m_flags = 2'b00;
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_t   = 0;
        m_tof1 = 0;
        m_tof2 = 0;
        h1 = '0;
        h2 = '0;
        model_new();
        exp_q.delete();
        exp_busy = 1'b0; exp_tx = 1'b0; exp_ms = 1'b0; exp_valid = 1'b0;
    endtask

    task automatic model_push();
        exp_q.push_back({m_flags, TW'(m_tof2), TW'(m_tof1)});
    endtask

    // A pin first sampled high at the end of cycle n is visible as an edge in cycle n+2.
    task automatic model_step();
        logic e1, e2;
        e1 = h1[1] & ~h1[2];
        e2 = h2[1] & ~h2[2];
        h1 = {h1[1:0], tripone};
        h2 = {h2[1:0], triptwo};
        if (!m_run) begin
            if (start || auto_en) begin
                m_run = 1'b1;
                m_t   = 0;
                model_new();
            end
        end else begin
            if (!m_ended && m_t >= LS) begin
                if (e1 && !m_c1) begin m_c1 = 1'b1; m_tof1 = m_t; end
                if (e2 && !m_c2) begin m_c2 = 1'b1; m_tof2 = m_t; end
                if (m_c1 && m_c2) begin
                    m_ended = 1'b1;
                    m_ms    = m_t + 1;
                end else if (m_t >= TMO) begin
                    m_ended = 1'b1;
                    m_vt    = m_t + 1;
                    if (!m_c1) begin m_tof1 = 0; m_flags[0] = 1'b1; end
                    if (!m_c2) begin m_tof2 = 0; m_flags[1] = 1'b1; end
                    model_push();
                end
            end else if (m_ended && m_vt == NONE) begin
                if (math_done) begin
                    m_vt = m_t + 1;
                    model_push();
                end
            end else if (m_vt != NONE && m_t >= m_vt) begin
                if (!auto_en) m_run = 1'b0;
                else if (m_t >= int'(period_cycles) - 1) begin
                    m_t = -1;
                    model_new();
                end
            end
            m_t++;
        end
        exp_busy  = m_run;
        exp_tx    = m_run && (m_t < BL) && ((m_t / HP) % 2 == 0);
        exp_ms    = m_run && (m_t == m_ms);
        exp_valid = m_run && (m_t == m_vt);
    endtask

    task automatic compare_cycle();
        logic [2*TW+1:0] want;
        cyc_n++;
        if (!reset) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("tx_out", 32'(tx_out), 32'(exp_tx));
            chk("math_start", 32'(math_start), 32'(exp_ms));
            chk("valid", 32'(valid), 32'(exp_valid));
            if (math_start) ms_cnt++;
            if (tx_out != tx_prev) tx_edges++;
            if (tx_out && !tx_prev) rises.push_back(cyc_n);
            if (valid) begin
                valid_cnt++;
                valid_cyc = cyc_n;
                chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    chk("sb_tof_one", 32'(tof_one), 32'(want[TW-1:0]));
                    chk("sb_tof_two", 32'(tof_two), 32'(want[2*TW-1:TW]));
                    chk("sb_flags", 32'(timeout_flags), 32'(want[2*TW+1:2*TW]));
                end
            end
        end
        tx_prev = tx_out;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        #1;
        rel++;
    endtask

    task automatic go_to(input int n);
        while (rel < n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        rel = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, ms0, v0, e0, r0;
        reset = 1'b1; start = 1'b0; auto_en = 1'b0; tripone = 1'b0; triptwo = 1'b0;
        math_done = 1'b0; period_cycles = 32'd0;
        model_reset();
        repeat (3) tick();
        #2 reset = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx", 32'(tx_out), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ms", 32'(math_start), 32'd0);
        chk("rst_tof_one", 32'(tof_one), 32'd0);
        chk("rst_tof_two", 32'(tof_two), 32'd0);
        chk("rst_flags", 32'(timeout_flags), 32'd0);

        // Single measurement: trips at 50/80, math_done 5 cycles after math_start.
        ms0 = ms_cnt; v0 = valid_cnt; e0 = tx_edges;
        pulse_start(); b0 = cyc_n + 1;
        go_to(50); tripone = 1'b1;
        go_to(80); triptwo = 1'b1;
        go_to(88); math_done = 1'b1; tick(); math_done = 1'b0;
        go_to(95); tripone = 1'b0; triptwo = 1'b0;
        go_to(100);
        chk("s1_tof_one", 32'(tof_one), 32'd52);
        chk("s1_tof_two", 32'(tof_two), 32'd82);
        chk("s1_flags", 32'(timeout_flags), 32'd0);
        chk("s1_ms_count", 32'(ms_cnt - ms0), 32'd1);
        chk("s1_valid_count", 32'(valid_cnt - v0), 32'd1);
        chk("s1_valid_at", 32'(valid_cyc - b0), 32'd89);
        chk("s1_tx_toggles", 32'(tx_edges - e0), 32'd4);
        chk("s1_busy_after", 32'(busy), 32'd0);

        // Timeout: only receiver 1 answers.
        ms0 = ms_cnt;
        pulse_start(); b0 = cyc_n + 1;
        go_to(50); tripone = 1'b1;
        go_to(210); tripone = 1'b0;
        go_to(215);
        chk("s2_flags", 32'(timeout_flags), 32'd2);
        chk("s2_tof_one", 32'(tof_one), 32'd52);
        chk("s2_tof_two", 32'(tof_two), 32'd0);
        chk("s2_ms_count", 32'(ms_cnt - ms0), 32'd0);
        chk("s2_valid_at", 32'(valid_cyc - b0), 32'd201);

        // Blanking: early pulses ignored, triptwo held high into LISTEN never captured.
        pulse_start();
        go_to(10); tripone = 1'b1;
        go_to(12); tripone = 1'b0;
        go_to(20); tripone = 1'b1; triptwo = 1'b1;
        go_to(22); tripone = 1'b0;
        go_to(60); tripone = 1'b1;
        go_to(205); tripone = 1'b0; triptwo = 1'b0;
        go_to(210);
        chk("s3_tof_one", 32'(tof_one), 32'd62);
        chk("s3_flags", 32'(timeout_flags), 32'd2);

        // Simultaneous edges; a stray math_done during LISTEN is ignored.
        ms0 = ms_cnt;
        pulse_start(); b0 = cyc_n + 1;
        go_to(30); math_done = 1'b1; tick(); math_done = 1'b0;
        go_to(40); tripone = 1'b1; triptwo = 1'b1;
        go_to(44); math_done = 1'b1; tick(); math_done = 1'b0;
        go_to(50); tripone = 1'b0; triptwo = 1'b0;
        go_to(55);
        chk("s4_tof_one", 32'(tof_one), 32'd42);
        chk("s4_tof_two", 32'(tof_two), 32'd42);
        chk("s4_flags", 32'(timeout_flags), 32'd0);
        chk("s4_ms_count", 32'(ms_cnt - ms0), 32'd1);
        chk("s4_valid_at", 32'(valid_cyc - b0), 32'd45);

        // Edge detected in the timeout cycle; a start while busy is ignored.
        v0 = valid_cnt;
        pulse_start(); b0 = cyc_n + 1;
        go_to(100); start = 1'b1; tick(); start = 1'b0;
        go_to(198); tripone = 1'b1;
        go_to(205); tripone = 1'b0;
        go_to(210);
        chk("s5_tof_one", 32'(tof_one), 32'd200);
        chk("s5_flags", 32'(timeout_flags), 32'd2);
        chk("s5_valid_at", 32'(valid_cyc - b0), 32'd201);
        chk("s5_valid_count", 32'(valid_cnt - v0), 32'd1);

        // Auto mode with period 400; auto_en dropped during the second LISTEN.
        ms0 = ms_cnt; r0 = rises.size();
        period_cycles = 32'd400;
        auto_en = 1'b1; tick(); rel = 0; b0 = cyc_n + 1;
        go_to(50); tripone = 1'b1;
        go_to(80); triptwo = 1'b1;
        go_to(88); math_done = 1'b1; tick(); math_done = 1'b0;
        go_to(95); tripone = 1'b0; triptwo = 1'b0;
        go_to(450); tripone = 1'b1;
        go_to(460); auto_en = 1'b0;
        go_to(480); triptwo = 1'b1;
        go_to(488); math_done = 1'b1; tick(); math_done = 1'b0;
        go_to(495); tripone = 1'b0; triptwo = 1'b0;
        go_to(520);
        chk("s6_rise_count", 32'(rises.size() - r0), 32'd4);
        if (rises.size() - r0 >= 3) begin
            chk("s6_first_entry", 32'(rises[r0] - b0), 32'd0);
            chk("s6_entry_gap", 32'(rises[r0 + 2] - rises[r0]), 32'd400);
        end
        chk("s6_valid_at", 32'(valid_cyc - b0), 32'd489);
        chk("s6_tof_one", 32'(tof_one), 32'd52);
        chk("s6_tof_two", 32'(tof_two), 32'd82);
        chk("s6_ms_count", 32'(ms_cnt - ms0), 32'd2);
        chk("s6_busy_after", 32'(busy), 32'd0);

        // Reset mid-BURST while tx_out is high, then a fresh measurement.
        period_cycles = 32'd0;
        pulse_start();
        go_to(2);
        chk("s7_tx_before_reset", 32'(tx_out), 32'd1);
        reset = 1'b1;
        #1;
        chk("s7_tx_async", 32'(tx_out), 32'd0);
        chk("s7_busy_async", 32'(busy), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        pulse_start(); b0 = cyc_n + 1;
        go_to(30); tripone = 1'b1; triptwo = 1'b1;
        go_to(35); math_done = 1'b1; tick(); math_done = 1'b0;
        go_to(40); tripone = 1'b0; triptwo = 1'b0;
        go_to(45);
        chk("s7_tof_one", 32'(tof_one), 32'd32);
        chk("s7_tof_two", 32'(tof_two), 32'd32);
        chk("s7_valid_at", 32'(valid_cyc - b0), 32'd36);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
